// File: rtl/ble_config_ctrl.sv
// rtl/ble_config_ctrl.sv - BLE configuration chain loader (word stream to serial chain).
// Optional CRC readback verify is enabled by defining BLE_CONFIG_READBACK_EN.
module ble_config_ctrl #(
    parameter int CHAIN_LEN = 65,
    parameter int WORD_W    = 8,
    parameter int CLK_DIV   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [WORD_W-1:0]                  word_data,
    input  logic                               word_valid,
    output logic                               word_ready,
    output logic                               config_in,
    output logic                               config_clk,
    output logic                               config_en,
    input  logic                               config_out,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(CHAIN_LEN+1)-1:0]     bit_count,
    output logic                               verify_ok,
    output logic                               verify_fail
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef BLE_CONFIG_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SHIFT_LOW, S_SHIFT_HIGH, S_FINISH, S_RB_LOW, S_RB_HIGH, S_CHECK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SHIFT_LOW, S_SHIFT_HIGH, S_FINISH
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0]  word_buf_q, word_buf_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic               config_in_q, config_in_d;
    logic               config_clk_q, config_clk_d;
    logic               config_en_q, config_en_d;

    logic               div_last;
    logic [IDX_W-1:0]   next_idx;
    logic [CNT_W-1:0]   count_inc;

`ifdef BLE_CONFIG_READBACK_EN
    logic [15:0]        crc_load_q, crc_load_d;
    logic [15:0]        crc_rb_q, crc_rb_d;
    logic [CNT_W-1:0]   rb_cnt_q, rb_cnt_d;
    logic               verify_ok_q, verify_ok_d;
    logic               verify_fail_q, verify_fail_d;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    assign div_last  = (div_q == DIV_W'(CLK_DIV - 1));
    assign next_idx  = bit_idx_q + 1'b1;
    assign count_inc = bit_count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        word_buf_d  = word_buf_q;
        bit_count_d = bit_count_q;
        config_in_d = config_in_q;
`ifdef BLE_CONFIG_READBACK_EN
        crc_load_d    = crc_load_q;
        crc_rb_d      = crc_rb_q;
        rb_cnt_d      = rb_cnt_q;
        verify_ok_d   = verify_ok_q;
        verify_fail_d = verify_fail_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    bit_count_d = '0;
                    config_in_d = 1'b0;
`ifdef BLE_CONFIG_READBACK_EN
                    crc_load_d    = 16'hFFFF;
                    crc_rb_d      = 16'hFFFF;
                    verify_ok_d   = 1'b0;
                    verify_fail_d = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (word_valid) begin
                    word_buf_d  = word_data;
                    bit_idx_d   = '0;
                    config_in_d = word_data[0];
                    div_d       = '0;
                    state_d     = S_SHIFT_LOW;
                end
            end
            S_SHIFT_LOW: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_SHIFT_HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT_HIGH: begin
                if (div_last) begin
                    div_d       = '0;
                    bit_count_d = count_inc;
`ifdef BLE_CONFIG_READBACK_EN
                    crc_load_d  = crc16_step(crc_load_q, config_in_q);
`endif
                    if (count_inc == CNT_W'(CHAIN_LEN)) begin
`ifdef BLE_CONFIG_READBACK_EN
                        rb_cnt_d    = '0;
                        config_in_d = config_out;
                        state_d     = S_RB_LOW;
`else
                        config_in_d = 1'b0;
                        state_d     = S_FINISH;
`endif
                    end else if (bit_idx_q == IDX_W'(WORD_W - 1)) begin
                        state_d = S_FETCH;
                    end else begin
                        bit_idx_d   = next_idx;
                        config_in_d = word_buf_q[next_idx];
                        state_d     = S_SHIFT_LOW;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`ifdef BLE_CONFIG_READBACK_EN
            // Rotation: the tail bit is fed back to the head so the chain ends up unchanged.
            S_RB_LOW: begin
                if (div_last) begin
                    div_d    = '0;
                    crc_rb_d = crc16_step(crc_rb_q, config_out);
                    state_d  = S_RB_HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_RB_HIGH: begin
                if (div_last) begin
                    div_d    = '0;
                    rb_cnt_d = rb_cnt_q + 1'b1;
                    if (rb_cnt_q + 1'b1 == CNT_W'(CHAIN_LEN)) begin
                        config_in_d = 1'b0;
                        state_d     = S_CHECK;
                    end else begin
                        config_in_d = config_out;
                        state_d     = S_RB_LOW;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_CHECK: begin
                verify_ok_d   = (crc_load_q == crc_rb_q);
                verify_fail_d = (crc_load_q != crc_rb_q);
                state_d       = S_FINISH;
            end
`endif
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Chain clock/enable are decoded from the next state so they flip on the same edge as the state.
        config_clk_d = 1'b0;
        config_en_d  = 1'b0;
        case (state_d)
            S_FETCH, S_SHIFT_LOW: config_en_d = 1'b1;
            S_SHIFT_HIGH: begin
                config_en_d  = 1'b1;
                config_clk_d = 1'b1;
            end
`ifdef BLE_CONFIG_READBACK_EN
            S_RB_LOW: config_en_d = 1'b1;
            S_RB_HIGH: begin
                config_en_d  = 1'b1;
                config_clk_d = 1'b1;
            end
`endif
            default: begin
                config_en_d  = 1'b0;
                config_clk_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            bit_idx_q    <= '0;
            word_buf_q   <= '0;
            bit_count_q  <= '0;
            config_in_q  <= 1'b0;
            config_clk_q <= 1'b0;
            config_en_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_idx_q    <= bit_idx_d;
            word_buf_q   <= word_buf_d;
            bit_count_q  <= bit_count_d;
            config_in_q  <= config_in_d;
            config_clk_q <= config_clk_d;
            config_en_q  <= config_en_d;
        end
    end

`ifdef BLE_CONFIG_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_load_q    <= 16'hFFFF;
            crc_rb_q      <= 16'hFFFF;
            rb_cnt_q      <= '0;
            verify_ok_q   <= 1'b0;
            verify_fail_q <= 1'b0;
        end else begin
            crc_load_q    <= crc_load_d;
            crc_rb_q      <= crc_rb_d;
            rb_cnt_q      <= rb_cnt_d;
            verify_ok_q   <= verify_ok_d;
            verify_fail_q <= verify_fail_d;
        end
    end

    assign verify_ok   = verify_ok_q;
    assign verify_fail = verify_fail_q;
`else
    logic unused_config_out;
    assign unused_config_out = config_out;
    assign verify_ok   = 1'b0;
    assign verify_fail = 1'b0;
`endif

    assign word_ready = (state_q == S_FETCH);
    assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done       = (state_q == S_FINISH);
    assign bit_count  = bit_count_q;
    assign config_in  = config_in_q;
    assign config_clk = config_clk_q;
    assign config_en  = config_en_q;

endmodule

// File: tb/tb_ble_config_ctrl.sv
// tb/tb_ble_config_ctrl.sv - directed self-checking bench for ble_config_ctrl with a behavioural chain.
module tb_ble_config_ctrl;

    localparam int CL = 65;
`ifdef BLE_CONFIG_READBACK_EN
    localparam int EXP_LAT = 1 + 9 + CL * 4 + CL * 4 + 1;
`else
    localparam int EXP_LAT = 1 + 9 + CL * 4;
`endif

    logic        clk = 1'b0;
    logic        rst, start, word_valid, config_out;
    logic [7:0]  word_data;
    logic        word_ready, config_in, config_clk, config_en, busy, done, verify_ok, verify_fail;
    logic [6:0]  bit_count;

    int compared = 0;
    int mismatched = 0;

    logic [7:0]    words [9];
    logic [CL-1:0] chain = '0;
    int            en_err = 0;
    int            flip_req = 0;
    int            flip_done = 0;

    ble_config_ctrl #(.CHAIN_LEN(CL), .WORD_W(8), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .config_in(config_in), .config_clk(config_clk),
        .config_en(config_en), .config_out(config_out), .busy(busy), .done(done),
        .bit_count(bit_count), .verify_ok(verify_ok), .verify_fail(verify_fail)
    );

    always #5 clk = ~clk;

    // Chain head is the MSB; stream bit i settles at chain[i] after a full load.
    assign config_out = chain[0];
    always @(posedge config_clk) begin
        logic [CL-1:0] c;
        c = chain;
        if (flip_req != flip_done) begin
            c[10] = ~c[10];
            flip_done <= flip_done + 1;
        end
        if (config_en !== 1'b1) en_err <= en_err + 1;
        chain <= {config_in, c[CL-1:1]};
    end

    task automatic set_words(input logic [7:0] first, input logic [7:0] mid, input logic [7:0] last);
        words[0] = first;
        for (int i = 1; i < 8; i++) words[i] = mid;
        words[8] = last;
    endtask

    task automatic run_load(input int stall_idx, input int stall_len, input int busy_start_at,
                            input int abort_bits, input int do_flip,
                            output int cyc, output int ndone, output int late_ready,
                            output int stall_bad);
        int wi, stall_cnt, done_cyc, n, flipped;
        wi = 0; stall_cnt = 0; done_cyc = 0; n = 0; flipped = 0;
        ndone = 0; late_ready = 0; stall_bad = 0;
        @(negedge clk);
        start = 1'b1;
        word_valid = 1'b0;
        @(negedge clk);
        while (n < 1500) begin
            n++;
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (done_cyc != 0 && n >= done_cyc + 5) break;
            if (word_ready && wi >= 9) late_ready++;
            if (abort_bits > 0 && int'(bit_count) == abort_bits) break;
            if (do_flip != 0 && int'(bit_count) == CL && flipped == 0) begin
                flip_req++;
                flipped = 1;
            end
            start = (n == busy_start_at);
            if (word_ready && wi == stall_idx && stall_cnt < stall_len) begin
                word_valid = 1'b0;
                stall_cnt++;
                if (config_clk !== 1'b0 || config_en !== 1'b1) stall_bad++;
            end else begin
                word_valid = (wi < 9);
                word_data  = (wi < 9) ? words[wi] : 8'h00;
            end
            if (word_ready && word_valid) wi++;
            @(negedge clk);
        end
        start = 1'b0;
        word_valid = 1'b0;
        cyc = done_cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
        compared++; if (word_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %b want 0", word_ready); end
        compared++; if (config_clk !== 1'b0) begin mismatched++; $display("FAIL reset_cclk got %b want 0", config_clk); end
        compared++; if (config_en !== 1'b0) begin mismatched++; $display("FAIL reset_cen got %b want 0", config_en); end
        compared++; if (config_in !== 1'b0) begin mismatched++; $display("FAIL reset_cin got %b want 0", config_in); end
        compared++; if (bit_count !== 7'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", bit_count); end
        compared++; if (verify_ok !== 1'b0 || verify_fail !== 1'b0) begin
            mismatched++; $display("FAIL reset_verify got %b%b want 00", verify_ok, verify_fail); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (busy !== 1'b0 || config_clk !== 1'b0) begin
            mismatched++; $display("FAIL idle_hold got busy=%b cclk=%b want 0/0", busy, config_clk); end
    endtask

    task automatic test_basic;
        int cyc, nd, lr, sb;
        set_words(8'h01, 8'h00, 8'h00);
        run_load(-1, 0, -1, 0, 0, cyc, nd, lr, sb);
        compared++; if (chain !== 65'h1) begin mismatched++; $display("FAIL basic_chain got %h want %h", chain, 65'h1); end
        compared++; if (cyc != EXP_LAT) begin mismatched++; $display("FAIL basic_latency got %0d want %0d", cyc, EXP_LAT); end
        compared++; if (bit_count !== 7'd65) begin mismatched++; $display("FAIL basic_count got %0d want 65", bit_count); end
        compared++; if (nd != 1) begin mismatched++; $display("FAIL basic_done_pulses got %0d want 1", nd); end
        compared++; if (lr != 0) begin mismatched++; $display("FAIL basic_late_ready got %0d want 0", lr); end
        compared++; if (busy !== 1'b0 || config_en !== 1'b0) begin
            mismatched++; $display("FAIL basic_idle got busy=%b cen=%b want 0/0", busy, config_en); end
`ifndef BLE_CONFIG_READBACK_EN
        compared++; if (verify_ok !== 1'b0) begin mismatched++; $display("FAIL basic_verify_tied got %b want 0", verify_ok); end
`endif
    endtask

    task automatic test_stall;
        int cyc, nd, lr, sb;
        set_words(8'h01, 8'h00, 8'h00);
        run_load(3, 20, -1, 0, 0, cyc, nd, lr, sb);
        compared++; if (chain !== 65'h1) begin mismatched++; $display("FAIL stall_chain got %h want %h", chain, 65'h1); end
        compared++; if (cyc != EXP_LAT + 20) begin mismatched++; $display("FAIL stall_latency got %0d want %0d", cyc, EXP_LAT + 20); end
        compared++; if (sb != 0) begin mismatched++; $display("FAIL stall_clk_en got %0d bad cycles want 0", sb); end
        compared++; if (nd != 1) begin mismatched++; $display("FAIL stall_done_pulses got %0d want 1", nd); end
    endtask

    task automatic test_tail_discard;
        int cyc, nd, lr, sb;
        set_words(8'h00, 8'h00, 8'hFF);
        run_load(-1, 0, -1, 0, 0, cyc, nd, lr, sb);
        compared++; if (chain !== {1'b1, 64'h0}) begin mismatched++; $display("FAIL tail_chain got %h want %h", chain, {1'b1, 64'h0}); end
        compared++; if (lr != 0) begin mismatched++; $display("FAIL tail_late_ready got %0d want 0", lr); end
        compared++; if (bit_count !== 7'd65) begin mismatched++; $display("FAIL tail_count got %0d want 65", bit_count); end
    endtask

    task automatic test_start_during_busy;
        int cyc, nd, lr, sb;
        set_words(8'h01, 8'h00, 8'h00);
        run_load(-1, 0, 50, 0, 0, cyc, nd, lr, sb);
        compared++; if (nd != 1) begin mismatched++; $display("FAIL busy_start_done got %0d want 1", nd); end
        compared++; if (cyc != EXP_LAT) begin mismatched++; $display("FAIL busy_start_latency got %0d want %0d", cyc, EXP_LAT); end
        compared++; if (chain !== 65'h1) begin mismatched++; $display("FAIL busy_start_chain got %h want %h", chain, 65'h1); end
    endtask

    task automatic test_reset_mid_load;
        int cyc, nd, lr, sb;
        logic [CL-1:0] exp_chain;
        exp_chain = {1'b1, {8{8'hA5}}};
        set_words(8'hA5, 8'hA5, 8'hA5);
        run_load(-1, 0, -1, 30, 0, cyc, nd, lr, sb);
        compared++; if (bit_count !== 7'd30) begin mismatched++; $display("FAIL mid_reached got %0d want 30", bit_count); end
        rst = 1'b1;
        #1;
        compared++; if (busy !== 1'b0 || word_ready !== 1'b0 || done !== 1'b0) begin
            mismatched++; $display("FAIL mid_reset_status got busy=%b rdy=%b done=%b want 000", busy, word_ready, done); end
        compared++; if (config_clk !== 1'b0 || config_en !== 1'b0 || config_in !== 1'b0) begin
            mismatched++; $display("FAIL mid_reset_chain got clk=%b en=%b in=%b want 000", config_clk, config_en, config_in); end
        compared++; if (bit_count !== 7'd0) begin mismatched++; $display("FAIL mid_reset_count got %0d want 0", bit_count); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_load(-1, 0, -1, 0, 0, cyc, nd, lr, sb);
        compared++; if (chain !== exp_chain) begin mismatched++; $display("FAIL a5_chain got %h want %h", chain, exp_chain); end
        compared++; if (cyc != EXP_LAT) begin mismatched++; $display("FAIL a5_latency got %0d want %0d", cyc, EXP_LAT); end
        compared++; if (en_err != 0) begin mismatched++; $display("FAIL en_at_rise got %0d bad edges want 0", en_err); end
    endtask

`ifdef BLE_CONFIG_READBACK_EN
    task automatic test_readback;
        int cyc, nd, lr, sb;
        logic [CL-1:0] exp_chain;
        exp_chain = {1'b1, {8{8'hA5}}};
        set_words(8'hA5, 8'hA5, 8'hA5);
        run_load(-1, 0, -1, 0, 0, cyc, nd, lr, sb);
        compared++; if (verify_ok !== 1'b1 || verify_fail !== 1'b0) begin
            mismatched++; $display("FAIL rb_ok got ok=%b fail=%b want 1/0", verify_ok, verify_fail); end
        compared++; if (chain !== exp_chain) begin mismatched++; $display("FAIL rb_chain got %h want %h", chain, exp_chain); end
        compared++; if (cyc != EXP_LAT) begin mismatched++; $display("FAIL rb_latency got %0d want %0d", cyc, EXP_LAT); end
        run_load(-1, 0, -1, 0, 1, cyc, nd, lr, sb);
        compared++; if (verify_ok !== 1'b0 || verify_fail !== 1'b1) begin
            mismatched++; $display("FAIL rb_fail got ok=%b fail=%b want 0/1", verify_ok, verify_fail); end
        compared++; if (nd != 1) begin mismatched++; $display("FAIL rb_done_pulses got %0d want 1", nd); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        word_valid = 1'b0;
        word_data = 8'h00;
        test_reset;
        test_basic;
        test_stall;
        test_tail_discard;
        test_start_during_busy;
        test_reset_mid_load;
`ifdef BLE_CONFIG_READBACK_EN
        test_readback;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ble_config_ctrl.md
Name: ble_config_ctrl

Overview:
- Configuration loader for a chain of BLE configuration shift registers (LUT bits plus FF-select bit per BLE, daisy-chained through config_out).
- Accepts the bitstream as WORD_W-bit words over a valid/ready handshake, serialises them LSB-first onto config_in and generates config_clk and config_en for the chain.
- Sits between the host/bitstream source and the fabric configuration chain. Fabric logic runs on clk and is unaffected.

Parameters:
- CHAIN_LEN, 65, total bits in the configuration chain (65 = one BLE).
- WORD_W, 8, width of an input bitstream word.
- CLK_DIV, 2, clk cycles per config_clk half-period (>=1).

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; ignored while busy.
- word_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  controller can accept a word.
- config_in  out  1  serial bit to chain head.
- config_clk  out  1  chain shift clock (registered, glitch-free).
- config_en  out  1  chain shift enable.
- config_out  in  1  serial bit from chain tail.
- busy  out  1  load (or verify) in progress.
- done  out  1  one-cycle pulse at end of operation.
- bit_count  out  $clog2(CHAIN_LEN+1)  bits shifted so far in the current load.
- verify_ok  out  1  readback CRC matched (feature only, else tied 0).
- verify_fail  out  1  readback CRC mismatched (feature only, else tied 0).

Behaviour:
- Reset (async, immediate): state IDLE; config_in, config_clk, config_en, word_ready, busy, done, verify_ok, verify_fail = 0; bit_count = 0; word buffer empty. Reset mid-load aborts; chain contents undefined.
- States: IDLE, FETCH, SHIFT_LOW, SHIFT_HIGH, FINISH (+ RB_LOW, RB_HIGH, CHECK with feature).
- IDLE: start=1 -> FETCH next cycle; busy=1, bit_count=0, verify flags cleared.
- FETCH: word_ready=1 while the buffer is empty. A word is captured on word_valid&word_ready (same edge), and the state goes to SHIFT_LOW with bit index 0. Stalls indefinitely without valid. config_clk held 0, config_en held 1.
- SHIFT_LOW: CLK_DIV cycles. config_clk=0, config_en=1, config_in=current buffer bit, set on entry and stable throughout.
- SHIFT_HIGH: CLK_DIV cycles. config_clk=1, config_in unchanged. On exit bit_count increments:
  - bit_count==CHAIN_LEN -> FINISH.
  - else if all WORD_W bits of the word are used -> FETCH.
  - else -> SHIFT_LOW with the next bit.
- Last word: bits beyond CHAIN_LEN are discarded. word_ready is not asserted again in that load.
- FINISH: config_en=0, config_clk=0, busy=0, done=1 for one cycle, then IDLE.
- No-stall latency: start to done = 1 + ceil(CHAIN_LEN/WORD_W) fetch cycles + CHAIN_LEN*2*CLK_DIV cycles (word presented when ready rises).
- config_en is never 1 while config_clk is rising with undefined config_in. config_clk never toggles outside SHIFT/RB states.
- start asserted during busy: no effect. word_valid outside FETCH: no effect.

Optional Feature:
- Macro: BLE_CONFIG_READBACK_EN.
- With the macro: during load, a CRC-16-CCITT (init 0xFFFF) is accumulated over every shifted config_in bit. FINISH is replaced by RB_LOW/RB_HIGH, which run CHAIN_LEN rotations with config_in=config_out. config_out is sampled in the last cycle of RB_LOW, and a second CRC is accumulated over those samples, so chain contents are restored. CHECK compares the two CRCs and sets verify_ok or verify_fail; these stay set until the next start. done pulses after CHECK. Added latency: CHAIN_LEN*2*CLK_DIV+1 cycles.
- Without the macro: no readback states or CRC logic; verify_ok/verify_fail tied 0.

Test Plan:
- Basic load (65/8/2): words 0x01,0x00 x8 -> behavioural chain model holds only bit 0 set; done at cycle 1+9+260; bit_count=65.
- Word stall: withhold word_valid 20 cycles before word 3 -> config_clk stays 0 and config_en 1 during the stall; final chain equals the no-stall result; done 20 cycles later.
- Tail discard: last word 0xFF -> only bit 64 set from it, 7 bits dropped; word_ready never reasserts after the 9th word.
- start during busy: pulse start at cycle 50 -> no restart; single done pulse.
- Reset mid-load: assert rst at bit 30 -> all outputs 0 in the same cycle; new start loads 0xA5 pattern correctly.
- Readback (macro on): load 0xA5 pattern -> verify_ok=1 and chain unchanged. Model flips chain bit 10 before readback -> verify_fail=1.
